// File: rtl/ringbus_pkg.sv
// Shared ringbus definitions: transmitter FSM states, word width and line levels.
// The receiver imports the same package.
package ringbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } rb_tx_state_t;

    localparam int unsigned RB_WORD_W      = 32;
    localparam logic        RB_IDLE_LEVEL  = 1'b1;
    localparam logic        RB_START_LEVEL = 1'b0;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic rb_parity(input logic [RB_WORD_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/ringbus_tx_fifo.sv
// Input word FIFO for ringbus_tx: registered head word, level and full/empty flags.
// The head register already holds the next word on the cycle after a pop or a write into an empty FIFO.
module ringbus_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_head;
    logic [AW-1:0]    w_head_slot;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_head;

    assign w_wr        = i_wr_en && !o_full;
    assign w_rd        = i_rd_en && !o_empty;
    assign w_head_slot = w_rd ? r_rd_ptr + AW'(1) : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
            // Bypass when the word landing this cycle becomes the new head.
            r_head  <= (w_wr && (w_head_slot == r_wr_ptr)) ? i_wr_data : r_mem[w_head_slot];
        end
    end

endmodule

// File: rtl/ringbus_tx.sv
// Ringbus serial transmitter: FIFO-buffered 32-bit words framed onto an idle-high line.
// Optional even-parity bit enabled by defining RINGBUS_TX_PARITY_EN.
module ringbus_tx
    import ringbus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [RB_WORD_W-1:0]        i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_ringbus,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    rb_tx_state_t         r_state;
    rb_tx_state_t         w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [4:0]           r_bit;
    logic [4:0]           w_bit_nxt;
    logic [GW-1:0]        r_gap;
    logic [GW-1:0]        w_gap_nxt;
    logic [RB_WORD_W-1:0] r_shift;
    logic [RB_WORD_W-1:0] w_shift_nxt;
    logic                 r_line;
    logic                 w_line_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_ready;
`ifdef RINGBUS_TX_PARITY_EN
    logic                 r_par;
    logic                 w_par_nxt;
`endif

    logic                 w_tick;
    logic                 w_frame_done;
    logic                 w_load;
    logic                 w_pop;
    logic                 w_accept;
    logic [RB_WORD_W-1:0] w_head;
    logic [LW-1:0]        w_level;
    logic [LW-1:0]        w_level_nxt;
    logic                 w_full;
    logic                 w_empty;

    assign w_accept    = i_valid && r_ready;
    assign w_level_nxt = w_level + LW'(w_accept) - LW'(w_pop);
    assign w_tick      = (r_cnt == '0);

    ringbus_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RB_WORD_W)
    ) u_fifo (
        .clk       (clk),
        .srst      (srst),
        .i_wr_en   (w_accept),
        .i_wr_data (i_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_level   (w_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_gap_nxt    = r_gap;
        w_shift_nxt  = r_shift;
        w_line_nxt   = r_line;
        w_busy_nxt   = r_busy;
        w_frame_done = 1'b0;
        w_load       = 1'b0;
        w_pop        = 1'b0;
`ifdef RINGBUS_TX_PARITY_EN
        w_par_nxt    = r_par;
`endif
        case (r_state)
            IDLE: begin
                w_load = !w_empty;
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                    w_cnt_nxt   = CNT_INIT;
                    w_line_nxt  = r_shift[0];
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_cnt_nxt = CNT_INIT;
                    w_bit_nxt = r_bit + 5'd1;
                    if (r_bit == 5'd31) begin
`ifdef RINGBUS_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_line_nxt  = r_par;
`else
                        w_state_nxt = STOP;
                        w_line_nxt  = RB_IDLE_LEVEL;
`endif
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[RB_WORD_W-1:1]};
                        w_line_nxt  = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
`ifdef RINGBUS_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_nxt = STOP;
                    w_cnt_nxt   = CNT_INIT;
                    w_line_nxt  = RB_IDLE_LEVEL;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (GAP_BITS > 0) begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = GAP_INIT;
                        w_cnt_nxt   = CNT_INIT;
                    end else begin
                        w_frame_done = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            GAP: begin
                if (w_tick) begin
                    w_cnt_nxt = CNT_INIT;
                    if (r_gap == '0) begin
                        w_frame_done = 1'b1;
                    end else begin
                        w_gap_nxt = r_gap - GW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_line_nxt  = RB_IDLE_LEVEL;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_frame_done) begin
            w_load      = !w_empty;
            w_state_nxt = IDLE;
            w_line_nxt  = RB_IDLE_LEVEL;
            w_busy_nxt  = 1'b0;
        end

        // A pop at frame end chains straight into the next start bit.
        if (w_load) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
            w_cnt_nxt   = CNT_INIT;
            w_line_nxt  = RB_START_LEVEL;
            w_busy_nxt  = 1'b1;
`ifdef RINGBUS_TX_PARITY_EN
            w_par_nxt   = rb_parity(w_head);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_shift <= '0;
            r_line  <= RB_IDLE_LEVEL;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
`ifdef RINGBUS_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_gap   <= w_gap_nxt;
            r_shift <= w_shift_nxt;
            r_line  <= w_line_nxt;
            r_busy  <= w_busy_nxt;
            // Drops as the last slot fills; rises only after a full cycle below full.
            r_ready <= (w_level_nxt != FIFO_DEPTH[LW-1:0]) && !w_full;
`ifdef RINGBUS_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    assign o_ringbus    = r_line;
    assign o_busy       = r_busy;
    assign o_ready      = r_ready;
    assign o_fifo_level = w_level;

endmodule

// File: tb/tb_ringbus_tx.sv
// Self-checking bench for ringbus_tx: two instances (defaults, and CLKS_PER_BIT=2/GAP_BITS=0)
// compared every cycle against a frame-level model, plus hand-computed timing points.
`timescale 1ns/1ps
module tb_ringbus_tx;

    localparam int NI = 2;
    localparam int D  = 8;
`ifdef RINGBUS_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic        clk = 1'b0;
    logic        sr   [NI];
    logic        v    [NI];
    logic [31:0] d    [NI];
    logic        rdy  [NI];
    logic        line [NI];
    logic        busy [NI];
    logic [3:0]  lvl  [NI];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    int max_lvl0 = 0;

    always #5 clk = ~clk;

    ringbus_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .GAP_BITS(2)) dut0 (
        .clk(clk), .srst(sr[0]), .i_data(d[0]), .i_valid(v[0]), .o_ready(rdy[0]),
        .o_ringbus(line[0]), .o_busy(busy[0]), .o_fifo_level(lvl[0]));

    ringbus_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(8), .GAP_BITS(0)) dut1 (
        .clk(clk), .srst(sr[1]), .i_data(d[1]), .i_valid(v[1]), .o_ready(rdy[1]),
        .o_ringbus(line[1]), .o_busy(busy[1]), .o_fifo_level(lvl[1]));

    function automatic int cpb(input int i);  return (i == 0) ? 4 : 2; endfunction
    function automatic int gapb(input int i); return (i == 0) ? 2 : 0; endfunction
    function automatic int flen(input int i); return (34 + P + gapb(i)) * cpb(i); endfunction

    // Line level for bit-period idx of a frame carrying word w.
    function automatic logic exp_bit(input logic [31:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 32) return w[idx-1];
        if (P == 1 && idx == 33) return ^w;
        return 1'b1;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", name, inst, cyc, act, exp);
        end
    endtask

    // Model: word queue plus the currently transmitted frame and its cycle offset.
    int          m_cnt [NI];
    logic [31:0] m_q   [NI][64];
    int          m_hd  [NI];
    int          m_tl  [NI];
    bit          m_act [NI];
    int          m_off [NI];
    logic [31:0] m_word[NI];
    bit          m_rdy [NI];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            int old;
            bit acc;
            bit pop;
            if (sr[i]) begin
                m_cnt[i] = 0; m_hd[i] = 0; m_tl[i] = 0;
                m_act[i] = 1'b0; m_off[i] = 0; m_rdy[i] = 1'b1;
            end else begin
                old = m_cnt[i];
                acc = v[i] && m_rdy[i];
                pop = (!m_act[i] || m_off[i] == flen(i) - 1) && old > 0;
                if (pop) begin
                    m_word[i] = m_q[i][m_hd[i] % 64];
                    m_hd[i]++;
                    m_act[i] = 1'b1;
                    m_off[i] = 0;
                end else if (m_act[i]) begin
                    m_off[i]++;
                    if (m_off[i] == flen(i)) m_act[i] = 1'b0;
                end
                if (acc) begin
                    m_q[i][m_tl[i] % 64] = d[i];
                    m_tl[i]++;
                end
                m_cnt[i] = old + int'(acc) - int'(pop);
                m_rdy[i] = (m_cnt[i] < D) && (old < D);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check("line",  i, line[i], m_act[i] ? exp_bit(m_word[i], m_off[i] / cpb(i)) : 1'b1);
                check("busy",  i, busy[i], m_act[i]);
                check("level", i, lvl[i], m_cnt[i]);
                check("ready", i, rdy[i], m_rdy[i]);
            end
            if (int'(lvl[0]) > max_lvl0) max_lvl0 = int'(lvl[0]);
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Caller must be 1 time unit after a posedge; returns likewise.
    task automatic offer(input int inst, input logic [31:0] w, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        v[inst] = 1'b1;
        d[inst] = w;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (rdy[inst]) begin
                acc = cyc;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout[%0d] cyc=%0d got=0 want=1", inst, cyc);
        end
        @(posedge clk); #1;
        v[inst] = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (!m_act[0] && !m_act[1] && m_cnt[0] == 0 && m_cnt[1] == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout cyc=%0d got=0 want=1", cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, a0, a8, a9, len0, len1;
        len0 = P ? 148 : 144;
        len1 = P ? 70 : 68;
        for (int i = 0; i < NI; i++) begin
            sr[i] = 1'b1; v[i] = 1'b0; d[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        sr[0] = 1'b0; sr[1] = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_line",  i, line[i], 1'b1);
            check("rst_ready", i, rdy[i],  1'b1);
            check("rst_busy",  i, busy[i], 1'b0);
            check("rst_level", i, lvl[i],  4'd0);
        end

        // Single word timing and bit placement.
        sync();
        offer(0, 32'hA5A5_0001, a);
        wait_cyc(a + 1);            check("pre_start", 0, line[0], 1'b1);
        wait_cyc(a + 2);            check("start_lo",  0, line[0], 1'b0);
                                    check("busy_rise", 0, busy[0], 1'b1);
        wait_cyc(a + 2 + 4 + 2);    check("bit0",      0, line[0], 1'b1);
        wait_cyc(a + 2 + 8 + 2);    check("bit1",      0, line[0], 1'b0);
        wait_cyc(a + 2 + 128 + 2);  check("bit31",     0, line[0], 1'b1);
        wait_cyc(a + 2 + 132 + 2);  check("bit33",     0, line[0], 1'b1);
        wait_cyc(a + 1 + len0);     check("busy_last", 0, busy[0], 1'b1);
        wait_cyc(a + 2 + len0);     check("busy_fall", 0, busy[0], 1'b0);
                                    check("idle_line", 0, line[0], 1'b1);

        // Back-to-back frames.
        wait_idle();
        sync();
        offer(0, 32'h1234_5678, a);
        offer(0, 32'h8000_0001, b);
        offer(0, 32'h0F0F_F0F0, b);
        wait_cyc(a + 1 + len0 - 8); check("gap_first", 0, line[0], 1'b1);
        wait_cyc(a + 1 + len0);     check("gap_last",  0, line[0], 1'b1);
        wait_cyc(a + 2 + len0);     check("b2b_start", 0, line[0], 1'b0);
        wait_cyc(a + 2 + 2*len0);   check("b2b_start3",0, line[0], 1'b0);

        // Backpressure with 10 words offered continuously.
        wait_idle();
        sync();
        max_lvl0 = 0;
        for (int k = 0; k < 10; k++) begin
            offer(0, $urandom, b);
            if (k == 0) a0 = b;
            if (k == 8) a8 = b;
            if (k == 9) a9 = b;
        end
        check("bp_consec",  0, a8 - a0, 8);
        check("bp_reopen",  0, a9 - a0, len0 + 3);
        wait_idle();
        check("bp_maxlvl",  0, max_lvl0, 8);

        // Reset during data bit 15.
        sync();
        offer(0, 32'hDEAD_BEEF, a);
        wait_cyc(a + 2 + 64 + 1);
        sr[0] = 1'b1;
        @(posedge clk); #1;
        sr[0] = 1'b0;
        @(negedge clk);
        check("mrst_line",  0, line[0], 1'b1);
        check("mrst_busy",  0, busy[0], 1'b0);
        check("mrst_level", 0, lvl[0],  4'd0);
        sync();
        offer(0, 32'hC001_D00D, a);
        wait_idle();

`ifdef RINGBUS_TX_PARITY_EN
        sync();
        offer(0, 32'h0000_0007, a);
        wait_cyc(a + 2 + 132 + 2);  check("par7",      0, line[0], 1'b1);
        wait_cyc(a + 2 + 147);      check("par_busy",  0, busy[0], 1'b1);
        wait_cyc(a + 2 + 148);      check("par_end",   0, busy[0], 1'b0);
        wait_idle();
        sync();
        offer(0, 32'h0000_0003, a);
        wait_cyc(a + 2 + 132 + 2);  check("par3",      0, line[0], 1'b0);
        wait_idle();
`endif

        // Edge values on the fast, gapless instance.
        sync();
        offer(1, 32'h0000_0000, a);
        offer(1, 32'hFFFF_FFFF, b);
        wait_cyc(a + 3);            check("e_start2",  1, line[1], 1'b0);
        wait_cyc(a + 4);            check("e_bit0",    1, line[1], 1'b0);
        wait_cyc(a + 1 + len1);     check("e_stop",    1, line[1], 1'b1);
        wait_cyc(a + 2 + len1);     check("e_next",    1, line[1], 1'b0);
                                    check("e_busy",    1, busy[1], 1'b1);
        wait_cyc(a + 3 + len1);     check("e_next2",   1, line[1], 1'b0);
        wait_cyc(a + 4 + len1);     check("e_ones0",   1, line[1], 1'b1);
        wait_idle();

        // Random traffic on both instances concurrently.
        fork
            begin
                int t0;
                sync();
                for (int k = 0; k < 12; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    offer(0, $urandom, t0);
                end
            end
            begin
                int t1;
                sync();
                for (int k = 0; k < 20; k++) begin
                    repeat ($urandom_range(0, 40)) begin @(posedge clk); #1; end
                    offer(1, $urandom, t1);
                end
            end
        join
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
